// File: rtl/e203_extend_csr_bank_pkg.sv
// Shared definitions for the NICE extended-CSR bank: default base address,
// register offsets relative to the base, and handshake FSM state encoding.
package e203_extend_csr_bank_pkg;

   localparam logic [11:0] E203_NICE_CSR_BASE = 12'hBC0;
   localparam int unsigned CSR_DATA_W         = 32;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_WAIT,
      HS_RESP
   } hs_state_e;

   // STATUS sits directly after the last control register
   function automatic logic [11:0] status_off(input int unsigned csr_num);
      return 12'(csr_num);
   endfunction

   // CYCLE sits directly after STATUS
   function automatic logic [11:0] cycle_off(input int unsigned csr_num);
      return 12'(csr_num + 1);
   endfunction

endpackage

// File: rtl/e203_extend_csr_bank_if.sv
// nice_csr access bus: valid/ready handshake with address, direction and data.
interface e203_extend_csr_bank_if;

   logic        nice_csr_valid;
   logic        nice_csr_ready;
   logic [31:0] nice_csr_addr;
   logic        nice_csr_wr;
   logic [31:0] nice_csr_wdata;
   logic [31:0] nice_csr_rdata;

   modport master (
      output nice_csr_valid,
      output nice_csr_addr,
      output nice_csr_wr,
      output nice_csr_wdata,
      input  nice_csr_ready,
      input  nice_csr_rdata
   );

   modport slave (
      input  nice_csr_valid,
      input  nice_csr_addr,
      input  nice_csr_wr,
      input  nice_csr_wdata,
      output nice_csr_ready,
      output nice_csr_rdata
   );

endinterface

// File: rtl/e203_extend_csr_bank_hs.sv
// Wait-state handshake for the nice_csr bus: produces ready and a one-cycle
// commit strobe (valid & ready) after WAIT cycles of held valid.
module e203_extend_csr_hs
   import e203_extend_csr_bank_pkg::*;
#(
   parameter int unsigned WAIT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic valid,
   output logic ready,
   output logic commit
);

   if (WAIT == 0) begin : g_nowait

      assign ready  = valid;
      assign commit = valid;

   end else begin : g_wait

      hs_state_e  state, state_nxt;
      logic [1:0] cnt, cnt_nxt;

      // state and wait counter registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= HS_IDLE;
            cnt   <= '0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
         end
      end

      // next-state and ready decode; RESP is entered on the edge where the
      // counter would reach zero so that ready lands exactly WAIT cycles
      // after valid first rises
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         ready     = 1'b0;
         case (state)
            HS_IDLE: begin
               if (valid) begin
                  if (WAIT == 1) begin
                     state_nxt = HS_RESP;
                  end else begin
                     state_nxt = HS_WAIT;
                     cnt_nxt   = 2'(WAIT - 1);
                  end
               end
            end
            HS_WAIT: begin
               if (!valid) begin
                  state_nxt = HS_IDLE;
                  cnt_nxt   = '0;
               end else if (cnt <= 2'd1) begin
                  state_nxt = HS_RESP;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - 2'd1;
               end
            end
            HS_RESP: begin
               ready     = 1'b1;
               state_nxt = HS_IDLE;
            end
            default: state_nxt = HS_IDLE;
         endcase
      end

      assign commit = ready & valid;

   end

endmodule

// File: rtl/e203_extend_csr_bank.sv
// NICE extended-CSR bank: CSR_NUM RW control registers, sticky W1C event
// STATUS and a writable free-running CYCLE counter behind the nice_csr bus.
module e203_extend_csr_bank
   import e203_extend_csr_bank_pkg::*;
#(
   parameter int unsigned CSR_NUM  = 4,
   parameter logic [11:0] CSR_BASE = E203_NICE_CSR_BASE,
   parameter int unsigned EVT_W    = 8,
   parameter int unsigned WAIT     = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   e203_extend_csr_bank_if.slave     csr,
   input  logic [EVT_W-1:0]          evt_i,
   output logic [32*CSR_NUM-1:0]     ctrl_o,
   output logic                      evt_pend_o
);

   localparam logic [11:0] STATUS_OFF = status_off(CSR_NUM);
   localparam logic [11:0] CYCLE_OFF  = cycle_off(CSR_NUM);

   logic                  commit;
   logic                  wr_en;
   logic                  hit;
   logic [11:0]           off;
   logic [CSR_NUM-1:0]    sel_ctrl;
   logic                  sel_status;
   logic                  sel_cycle;
   logic [CSR_DATA_W-1:0] ctrl_q [CSR_NUM];
   logic [EVT_W-1:0]      status_q;
   logic [EVT_W-1:0]      status_clr;
   logic [CSR_DATA_W-1:0] cycle_q;
   logic [CSR_DATA_W-1:0] rd;

   e203_extend_csr_hs #(
      .WAIT (WAIT)
   ) u_hs (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (csr.nice_csr_valid),
      .ready  (csr.nice_csr_ready),
      .commit (commit)
   );

   assign wr_en = commit & csr.nice_csr_wr;
   assign hit   = (csr.nice_csr_addr[31:12] == '0);
   assign off   = csr.nice_csr_addr[11:0] - CSR_BASE;

   // address decode relative to the bank base
   always_comb begin
      sel_ctrl = '0;
      for (int unsigned i = 0; i < CSR_NUM; i++) begin
         if (hit && (off == 12'(i))) sel_ctrl[i] = 1'b1;
      end
      sel_status = hit && (off == STATUS_OFF);
      sel_cycle  = hit && (off == CYCLE_OFF);
   end

   for (genvar g = 0; g < CSR_NUM; g++) begin : g_ctrl
      // control register g, written on a committed write
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ctrl_q[g] <= '0;
         end else if (wr_en && sel_ctrl[g]) begin
            ctrl_q[g] <= csr.nice_csr_wdata;
         end
      end
      assign ctrl_o[32*g +: 32] = ctrl_q[g];
   end

   assign status_clr = (wr_en && sel_status) ? csr.nice_csr_wdata[EVT_W-1:0] : '0;

   // sticky event flags; a new event in the clearing cycle takes priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
      end else begin
         status_q <= (status_q & ~status_clr) | evt_i;
      end
   end

   // free-running cycle counter; a write replaces that cycle's increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q <= '0;
      end else if (wr_en && sel_cycle) begin
         cycle_q <= csr.nice_csr_wdata;
      end else begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

   // read mux from current register state, zero outside a completing transfer
   always_comb begin
      rd = '0;
      if (commit) begin
         for (int unsigned i = 0; i < CSR_NUM; i++) begin
            if (sel_ctrl[i]) rd = ctrl_q[i];
         end
         if (sel_status) rd[EVT_W-1:0] = status_q;
         if (sel_cycle)  rd = cycle_q;
      end
   end

   assign csr.nice_csr_rdata = rd;
   assign evt_pend_o         = |status_q;

endmodule

// File: tb/tb_e203_extend_csr_bank.sv
// Scoreboard bench for e203_extend_csr_bank: one instance with WAIT=0 and one
// with WAIT=2; read expectations are queued at issue and checked by a monitor.
module tb_e203_extend_csr_bank;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  evt0, evt2;
   logic [127:0] ctrl0, ctrl2;
   logic        pend0, pend2;
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          done    = 1'b0;
   exp_t        q0[$];
   exp_t        q2[$];

   always #5 clk = ~clk;

   e203_extend_csr_bank_if bus0 ();
   e203_extend_csr_bank_if bus2 ();

   e203_extend_csr_bank #(
      .CSR_NUM  (4),
      .CSR_BASE (12'hBC0),
      .EVT_W    (8),
      .WAIT     (0)
   ) u_dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .csr        (bus0),
      .evt_i      (evt0),
      .ctrl_o     (ctrl0),
      .evt_pend_o (pend0)
   );

   e203_extend_csr_bank #(
      .CSR_NUM  (4),
      .CSR_BASE (12'hBC0),
      .EVT_W    (8),
      .WAIT     (2)
   ) u_dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .csr        (bus2),
      .evt_i      (evt2),
      .ctrl_o     (ctrl2),
      .evt_pend_o (pend2)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic check_ctrl(input bit d2, input string name, input logic [127:0] exp);
      logic [127:0] act;
      act = d2 ? ctrl2 : ctrl0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s[%0d]", name, i), act[32*i +: 32], exp[32*i +: 32]);
      end
   endtask

   // issue one access; reads queue their expected data; lat returns the
   // number of cycles from request to ready
   task automatic acc(input bit d2, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp,
                      input string name, output int lat);
      exp_t e;
      bit   rdy;
      if (!wr) begin
         e.name = name;
         e.exp  = exp;
         if (d2) q2.push_back(e);
         else    q0.push_back(e);
      end
      if (d2) begin
         bus2.nice_csr_valid = 1'b1; bus2.nice_csr_wr = wr;
         bus2.nice_csr_addr  = addr; bus2.nice_csr_wdata = wdata;
      end else begin
         bus0.nice_csr_valid = 1'b1; bus0.nice_csr_wr = wr;
         bus0.nice_csr_addr  = addr; bus0.nice_csr_wdata = wdata;
      end
      lat = 0;
      @(negedge clk);
      rdy = d2 ? bus2.nice_csr_ready : bus0.nice_csr_ready;
      while (!rdy && lat < 20) begin
         lat++;
         @(negedge clk);
         rdy = d2 ? bus2.nice_csr_ready : bus0.nice_csr_ready;
      end
      if (!rdy) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: timeout, ready never seen after %0d cycles", name, lat);
      end
      @(posedge clk);
      #1;
      if (d2) bus2.nice_csr_valid = 1'b0;
      else    bus0.nice_csr_valid = 1'b0;
   endtask

   initial begin
      int lat;
      bus0.nice_csr_valid = 1'b0; bus0.nice_csr_wr = 1'b0;
      bus0.nice_csr_addr  = '0;   bus0.nice_csr_wdata = '0;
      bus2.nice_csr_valid = 1'b0; bus2.nice_csr_wr = 1'b0;
      bus2.nice_csr_addr  = '0;   bus2.nice_csr_wdata = '0;
      evt0 = '0;
      evt2 = '0;

      fork
         // monitor: compare every completing read against the scoreboard
         begin
            exp_t e;
            while (!done) begin
               @(negedge clk);
               if (bus0.nice_csr_valid && bus0.nice_csr_ready) begin
                  if (!bus0.nice_csr_wr) begin
                     if (q0.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL dut0_unexpected_read: got %h expected none", bus0.nice_csr_rdata);
                     end else begin
                        e = q0.pop_front();
                        check(e.name, bus0.nice_csr_rdata, e.exp);
                     end
                  end
               end else begin
                  check("dut0_rdata_idle", bus0.nice_csr_rdata, 32'h0);
               end
               if (bus2.nice_csr_valid && bus2.nice_csr_ready) begin
                  if (!bus2.nice_csr_wr) begin
                     if (q2.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL dut2_unexpected_read: got %h expected none", bus2.nice_csr_rdata);
                     end else begin
                        e = q2.pop_front();
                        check(e.name, bus2.nice_csr_rdata, e.exp);
                     end
                  end
               end else begin
                  check("dut2_rdata_idle", bus2.nice_csr_rdata, 32'h0);
               end
            end
         end
         // stimulus
         begin
            // reset state
            repeat (2) @(negedge clk);
            check_ctrl(1'b0, "rst_ctrl0", 128'h0);
            check("rst_pend0", 32'(pend0), 32'h0);
            check("rst_ready2", 32'(bus2.nice_csr_ready), 32'h0);
            rst_n = 1'b1;

            // 1: five idle cycles, then CYCLE reads 5 (pre-increment value)
            repeat (5) @(posedge clk);
            #1;
            acc(1'b0, 1'b0, 32'h0000_0BC5, 32'h0, 32'd5, "cycle_after_reset", lat);
            check("lat0_cycle", 32'(lat), 32'd0);

            // 2: WAIT=0 back-to-back write/read of CTRL[2]
            acc(1'b0, 1'b1, 32'h0000_0BC2, 32'hDEAD_BEEF, 32'h0, "wr_ctrl2", lat);
            check("lat0_wr", 32'(lat), 32'd0);
            acc(1'b0, 1'b0, 32'h0000_0BC2, 32'h0, 32'hDEAD_BEEF, "rd_ctrl2", lat);
            check("lat0_rd", 32'(lat), 32'd0);
            check("ctrl0_slice2", ctrl0[95:64], 32'hDEAD_BEEF);

            // 3: WAIT=2 latency, write/read, aborted write
            acc(1'b1, 1'b0, 32'h0000_0BC0, 32'h0, 32'h0, "dut2_rd_ctrl0", lat);
            check("lat2_rd", 32'(lat), 32'd2);
            acc(1'b1, 1'b1, 32'h0000_0BC3, 32'hCAFE_F00D, 32'h0, "dut2_wr_ctrl3", lat);
            check("lat2_wr", 32'(lat), 32'd2);
            acc(1'b1, 1'b0, 32'h0000_0BC3, 32'h0, 32'hCAFE_F00D, "dut2_rd_ctrl3", lat);
            check("ctrl2_slice3", ctrl2[127:96], 32'hCAFE_F00D);
            bus2.nice_csr_valid = 1'b1; bus2.nice_csr_wr = 1'b1;
            bus2.nice_csr_addr  = 32'h0000_0BC1; bus2.nice_csr_wdata = 32'h1234_5678;
            @(negedge clk);
            check("abort_ready_t0", 32'(bus2.nice_csr_ready), 32'h0);
            @(posedge clk); #1;
            bus2.nice_csr_valid = 1'b0;
            @(negedge clk);
            check("abort_ready_t1", 32'(bus2.nice_csr_ready), 32'h0);
            repeat (3) @(posedge clk);
            #1;
            check("abort_ctrl1", ctrl2[63:32], 32'h0);
            acc(1'b1, 1'b0, 32'h0000_0BC1, 32'h0, 32'h0, "dut2_rd_ctrl1", lat);
            check("lat2_after_abort", 32'(lat), 32'd2);

            // 4: sticky STATUS, W1C with simultaneous set, clear
            evt0 = 8'h05;
            @(posedge clk); #1;
            evt0 = 8'h00;
            check("pend_set", 32'(pend0), 32'h1);
            acc(1'b0, 1'b0, 32'h0000_0BC4, 32'h0, 32'h05, "status_05", lat);
            evt0 = 8'h01;
            acc(1'b0, 1'b1, 32'h0000_0BC4, 32'h1, 32'h0, "w1c_vs_set", lat);
            evt0 = 8'h00;
            acc(1'b0, 1'b0, 32'h0000_0BC4, 32'h0, 32'h05, "status_set_wins", lat);
            acc(1'b0, 1'b1, 32'h0000_0BC4, 32'h5, 32'h0, "w1c_all", lat);
            check("pend_clear", 32'(pend0), 32'h0);
            acc(1'b0, 1'b0, 32'h0000_0BC4, 32'h0, 32'h0, "status_cleared", lat);
            evt0 = 8'h80;
            @(posedge clk); #1;
            evt0 = 8'h00;
            acc(1'b0, 1'b0, 32'h0000_0BC4, 32'h0, 32'h80, "status_bit7", lat);
            acc(1'b0, 1'b1, 32'h0000_0BC4, 32'hFFFF_FFFF, 32'h0, "w1c_ones", lat);
            check("pend_clear2", 32'(pend0), 32'h0);

            // 5: CYCLE write and wrap
            acc(1'b0, 1'b1, 32'h0000_0BC5, 32'hFFFF_FFFE, 32'h0, "wr_cycle", lat);
            acc(1'b0, 1'b0, 32'h0000_0BC5, 32'h0, 32'hFFFF_FFFE, "cycle_fe", lat);
            acc(1'b0, 1'b0, 32'h0000_0BC5, 32'h0, 32'hFFFF_FFFF, "cycle_ff", lat);
            acc(1'b0, 1'b0, 32'h0000_0BC5, 32'h0, 32'h0000_0000, "cycle_wrap", lat);

            // 6: unmapped accesses
            acc(1'b0, 1'b1, 32'h0000_1BC0, 32'h0000_0055, 32'h0, "wr_unmapped_hi", lat);
            check("lat0_unmapped", 32'(lat), 32'd0);
            acc(1'b0, 1'b0, 32'h0000_1BC0, 32'h0, 32'h0, "rd_unmapped_hi", lat);
            acc(1'b0, 1'b1, 32'h0000_0BC6, 32'h0000_0077, 32'h0, "wr_unmapped_bc6", lat);
            acc(1'b0, 1'b0, 32'h0000_0BC6, 32'h0, 32'h0, "rd_unmapped_bc6", lat);
            check_ctrl(1'b0, "ctrl0_after_unmapped", 128'h00000000_DEADBEEF_00000000_00000000);
            acc(1'b1, 1'b1, 32'h0000_0BC7, 32'h0000_0099, 32'h0, "dut2_wr_unmapped", lat);
            check("lat2_unmapped", 32'(lat), 32'd2);

            // 6: asynchronous reset in the middle of a WAIT=2 access
            evt0 = 8'h10;
            @(posedge clk); #1;
            evt0 = 8'h00;
            check("pend_before_rst", 32'(pend0), 32'h1);
            bus2.nice_csr_valid = 1'b1; bus2.nice_csr_wr = 1'b0;
            bus2.nice_csr_addr  = 32'h0000_0BC3; bus2.nice_csr_wdata = 32'h0;
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            check("rst_mid_ready2", 32'(bus2.nice_csr_ready), 32'h0);
            check("rst_mid_rdata2", bus2.nice_csr_rdata, 32'h0);
            check("rst_mid_pend0", 32'(pend0), 32'h0);
            check_ctrl(1'b1, "rst_mid_ctrl2", 128'h0);
            check_ctrl(1'b0, "rst_mid_ctrl0", 128'h0);
            bus2.nice_csr_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            acc(1'b1, 1'b0, 32'h0000_0BC3, 32'h0, 32'h0, "dut2_ctrl3_after_rst", lat);
            check("lat2_after_rst", 32'(lat), 32'd2);
            acc(1'b0, 1'b0, 32'h0000_0BC5, 32'h0, 32'd4, "cycle_after_rst", lat);

            repeat (2) @(posedge clk);
            done = 1'b1;
         end
      join

      check("q0_drained", 32'(q0.size()), 32'h0);
      check("q2_drained", 32'(q2.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
